// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: shadow/active glyph registers with
// frame-synchronous transfer, per-digit dp/blank/blink and anode dead time.
module seg_scan_driver #(
    parameter int NUM_DIGITS       = 6,
    parameter int REFRESH_DIV      = 50000,
    parameter int DEAD_CYCLES      = 16,
    parameter int BLINK_DIV        = 64,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            load,
    input  logic [5*NUM_DIGITS-1:0]         codes_in,
    input  logic [NUM_DIGITS-1:0]           dp_in,
    input  logic [NUM_DIGITS-1:0]           blank_in,
    input  logic [NUM_DIGITS-1:0]           blink_in,
    output logic [7:0]                      seg_out,
    output logic [NUM_DIGITS-1:0]           anode_out,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
    output logic                            frame_tick
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0]         LP_CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]         LP_DEAD       = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0]         LP_IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0]         LP_BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] LP_ANODE_OFF  = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

    function automatic logic [7:0] f_glyph(input logic [4:0] code);
        logic [7:0] g;
        case (code)
            5'd0:    g = 8'hC0;
            5'd1:    g = 8'hF9;
            5'd2:    g = 8'hA4;
            5'd3:    g = 8'hB0;
            5'd4:    g = 8'h99;
            5'd5:    g = 8'h92;
            5'd6:    g = 8'h82;
            5'd7:    g = 8'hF8;
            5'd8:    g = 8'h80;
            5'd9:    g = 8'h90;
            5'd10:   g = 8'h88;
            5'd11:   g = 8'h83;
            5'd12:   g = 8'hC6;
            5'd13:   g = 8'hA1;
            5'd14:   g = 8'h86;
            5'd15:   g = 8'h8E;
            5'd16:   g = 8'hAF;
            5'd17:   g = 8'hA1;
            5'd18:   g = 8'h87;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [BW-1:0]           r_blink_cnt;
    logic                    r_blink_phase;
    logic                    r_pending;
    logic [5*NUM_DIGITS-1:0] r_sh_codes;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank;
    logic [NUM_DIGITS-1:0]   r_sh_blink;
    logic [5*NUM_DIGITS-1:0] r_act_codes;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic [NUM_DIGITS-1:0]   r_act_blink;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic                    r_frame_tick;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic [NUM_DIGITS-1:0]   w_anode_on;
    logic [7:0]              w_glyph [2**IW];

    assign w_slot_end  = enable && (r_cnt == LP_CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == LP_IDX_LAST);
    assign w_anode_on  = NUM_DIGITS'(1) << r_idx;

    // Scan position: prescaler within a slot, digit index across slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == LP_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else if (enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A load on the boundary cycle refills the shadow but the active set
    // still takes the pre-load shadow; the new data waits one more frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= 1'b0;
            r_sh_codes  <= {NUM_DIGITS{5'd31}};
            r_sh_dp     <= '0;
            r_sh_blank  <= '0;
            r_sh_blink  <= '0;
            r_act_codes <= {NUM_DIGITS{5'd31}};
            r_act_dp    <= '0;
            r_act_blank <= '0;
            r_act_blink <= '0;
        end else begin
            if (w_frame_end && r_pending) begin
                r_act_codes <= r_sh_codes;
                r_act_dp    <= r_sh_dp;
                r_act_blank <= r_sh_blank;
                r_act_blink <= r_sh_blink;
            end
            if (load) begin
                r_sh_codes <= codes_in;
                r_sh_dp    <= dp_in;
                r_sh_blank <= blank_in;
                r_sh_blink <= blink_in;
                r_pending  <= 1'b1;
            end else if (w_frame_end) begin
                r_pending  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_frame_end) begin
            if (r_blink_cnt == LP_BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Per-digit visible pattern; unused table slots (non power-of-two counts) stay dark.
    always_comb begin
        for (int i = 0; i < 2**IW; i++) begin
            w_glyph[i] = 8'hFF;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!(r_act_blank[i] || (r_act_blink[i] && !r_blink_phase))) begin
                w_glyph[i] = f_glyph(r_act_codes[5*i +: 5]);
                if (r_act_dp[i]) begin
                    w_glyph[i][7] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg        <= 8'hFF;
            r_anode      <= LP_ANODE_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
            if (enable && (r_cnt >= LP_DEAD)) begin
                r_seg   <= w_glyph[r_idx];
                r_anode <= LP_ANODE_OFF ^ w_anode_on;
            end else begin
                r_seg   <= 8'hFF;
                r_anode <= LP_ANODE_OFF;
            end
        end
    end

    assign seg_out    = r_seg;
    assign anode_out  = r_anode;
    assign digit_idx  = r_idx;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: scan position derived from a count of enabled
// cycles, display content from a shadow/active model of loads and frames.
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int DC = 1;
    localparam int BD = 2;
    localparam int FR = RD * N;

    localparam logic [7:0] GLYPH [32] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,
        8'hAF, 8'hA1, 8'h87, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    logic           clk = 1'b0;
    logic           rst, enable, load;
    logic [5*N-1:0] codes_in;
    logic [N-1:0]   dp_in, blank_in, blink_in;
    logic [7:0]     seg_out;
    logic [N-1:0]   anode_out;
    logic [1:0]     digit_idx;
    logic           frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: E = enabled cycles since reset, nframes = boundaries passed.
    int           E, nframes;
    bit           m_pending;
    logic [4:0]   m_sh_code [N];
    logic [4:0]   m_act_code[N];
    logic [N-1:0] m_sh_dp, m_sh_blank, m_sh_blink;
    logic [N-1:0] m_act_dp, m_act_blank, m_act_blink;
    logic [7:0]   exp_seg;
    logic [N-1:0] exp_an;
    logic [1:0]   exp_idx;
    logic         exp_tick;

    seg_scan_driver #(
        .NUM_DIGITS(N), .REFRESH_DIV(RD), .DEAD_CYCLES(DC),
        .BLINK_DIV(BD), .ANODE_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .codes_in(codes_in), .dp_in(dp_in), .blank_in(blank_in), .blink_in(blink_in),
        .seg_out(seg_out), .anode_out(anode_out), .digit_idx(digit_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] vis(int d);
        logic [7:0] g;
        if (m_act_blank[d] || (m_act_blink[d] && ((nframes / BD) % 2 == 1)))
            return 8'hFF;
        g = GLYPH[m_act_code[d]];
        if (m_act_dp[d]) g[7] = 1'b0;
        return g;
    endfunction

    // Predict the outputs produced by the coming edge, then take the edge.
    task automatic step();
        int cnt, idx;
        if (rst) begin
            E = 0; nframes = 0; m_pending = 0;
            for (int i = 0; i < N; i++) begin
                m_sh_code[i] = 5'd31; m_act_code[i] = 5'd31;
            end
            m_sh_dp = '0; m_sh_blank = '0; m_sh_blink = '0;
            m_act_dp = '0; m_act_blank = '0; m_act_blink = '0;
            exp_seg = 8'hFF; exp_an = '1; exp_idx = 2'd0; exp_tick = 1'b0;
        end else begin
            cnt = E % RD;
            idx = (E / RD) % N;
            exp_tick = enable && (E % FR == FR - 1);
            if (enable && cnt >= DC) begin
                exp_seg = vis(idx);
                exp_an  = ~(4'(1) << idx);
            end else begin
                exp_seg = 8'hFF;
                exp_an  = '1;
            end
            if (exp_tick) begin
                nframes++;
                if (m_pending) begin
                    for (int i = 0; i < N; i++) m_act_code[i] = m_sh_code[i];
                    m_act_dp = m_sh_dp; m_act_blank = m_sh_blank; m_act_blink = m_sh_blink;
                    m_pending = 0;
                end
            end
            if (load) begin
                for (int i = 0; i < N; i++) m_sh_code[i] = codes_in[5*i +: 5];
                m_sh_dp = dp_in; m_sh_blank = blank_in; m_sh_blink = blink_in;
                m_pending = 1;
            end
            if (enable) E++;
            exp_idx = 2'((E / RD) % N);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_codes(input int c3, input int c2, input int c1, input int c0);
        codes_in = {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
    endtask

    task automatic test_reset();
        rst = 1; enable = 0; load = 0;
        codes_in = '0; dp_in = '0; blank_in = '0; blink_in = '0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if ({seg_out, anode_out, digit_idx, frame_tick} !== {8'hFF, 4'hF, 2'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset: seg/an/idx/tick got %h/%h/%0d/%0d want FF/F/0/0",
                         seg_out, anode_out, digit_idx, frame_tick);
            end
        end
        rst = 0;
    endtask

    task automatic test_scan();
        int ticks;
        logic [7:0] d3_first, d3_second;
        ticks = 0; d3_first = 8'h00; d3_second = 8'h00;
        enable = 1; load = 1;
        set_codes(16, 10, 2, 1);
        for (int k = 0; k < 48; k++) begin
            step();
            load = 0;
            if (frame_tick) ticks++;
            if (anode_out == 4'h7) begin
                if (E <= FR) d3_first = seg_out;
                else if (E <= 2 * FR) d3_second = seg_out;
            end
            n_checks++;
            if ({seg_out, anode_out, digit_idx, frame_tick} !== {exp_seg, exp_an, exp_idx, exp_tick}) begin
                n_fail++;
                $display("FAIL scan E=%0d: got %h/%h/%0d/%0d want %h/%h/%0d/%0d", E,
                         seg_out, anode_out, digit_idx, frame_tick, exp_seg, exp_an, exp_idx, exp_tick);
            end
        end
        n_checks++;
        if (ticks !== 3) begin
            n_fail++;
            $display("FAIL scan_ticks: got %0d want 3", ticks);
        end
        n_checks++;
        if ({d3_first, d3_second} !== {8'hFF, 8'hAF}) begin
            n_fail++;
            $display("FAIL scan_digit3: got %h then %h want FF then AF", d3_first, d3_second);
        end
    endtask

    task automatic test_dp_codes();
        logic [7:0] d [N];
        for (int i = 0; i < N; i++) d[i] = 8'h00;
        load = 1;
        set_codes(25, 10, 17, 1);
        dp_in = 4'b0101; blank_in = 4'b0001;
        for (int k = 0; k < 3 * FR; k++) begin
            step();
            load = 0;
            for (int i = 0; i < N; i++)
                if (anode_out == ~(4'(1) << i)) d[i] = seg_out;
            n_checks++;
            if ({seg_out, anode_out, digit_idx, frame_tick} !== {exp_seg, exp_an, exp_idx, exp_tick}) begin
                n_fail++;
                $display("FAIL dp_codes E=%0d: got %h/%h/%0d/%0d want %h/%h/%0d/%0d", E,
                         seg_out, anode_out, digit_idx, frame_tick, exp_seg, exp_an, exp_idx, exp_tick);
            end
        end
        n_checks++;
        if ({d[3], d[2], d[1], d[0]} !== {8'hFF, 8'h08, 8'hA1, 8'hFF}) begin
            n_fail++;
            $display("FAIL dp_glyphs: got %h %h %h %h want FF 08 A1 FF", d[3], d[2], d[1], d[0]);
        end
        dp_in = '0; blank_in = '0;
    endtask

    task automatic test_blink();
        int ticks, on_cnt, off_cnt, steady_bad;
        ticks = 0; on_cnt = 0; off_cnt = 0; steady_bad = 0;
        load = 1;
        set_codes(16, 10, 2, 1);
        blink_in = 4'b0010;
        for (int k = 0; k < 64 && ticks < 2; k++) begin
            step();
            load = 0;
            if (frame_tick) ticks++;
        end
        n_checks++;
        if (ticks !== 2) begin
            n_fail++;
            $display("FAIL blink_sync: frame ticks got %0d want 2", ticks);
        end
        for (int k = 0; k < 8 * FR; k++) begin
            step();
            if (anode_out == 4'hD) begin
                if (seg_out == 8'hA4) on_cnt++;
                else if (seg_out == 8'hFF) off_cnt++;
            end
            if (anode_out == 4'hB && seg_out != 8'h88) steady_bad++;
            n_checks++;
            if ({seg_out, anode_out, digit_idx, frame_tick} !== {exp_seg, exp_an, exp_idx, exp_tick}) begin
                n_fail++;
                $display("FAIL blink E=%0d: got %h/%h/%0d/%0d want %h/%h/%0d/%0d", E,
                         seg_out, anode_out, digit_idx, frame_tick, exp_seg, exp_an, exp_idx, exp_tick);
            end
        end
        n_checks++;
        if ({on_cnt, off_cnt, steady_bad} !== {32'd12, 32'd12, 32'd0}) begin
            n_fail++;
            $display("FAIL blink_duty: on %0d off %0d steady_bad %0d want 12 12 0",
                     on_cnt, off_cnt, steady_bad);
        end
        blink_in = '0;
    endtask

    task automatic test_load_timing();
        logic [7:0] f1, f2;
        f1 = 8'h00; f2 = 8'h00;
        for (int k = 0; k < 64 && (E % FR) != RD + 1; k++) step();
        load = 1; set_codes(5, 5, 5, 5);
        step();
        load = 0;
        for (int k = 0; k < 64 && (E % FR) != FR - 1; k++) begin
            step();
            n_checks++;
            if ({seg_out, anode_out} !== {exp_seg, exp_an}) begin
                n_fail++;
                $display("FAIL load_mid E=%0d: got %h/%h want %h/%h", E, seg_out, anode_out, exp_seg, exp_an);
            end
        end
        load = 1; set_codes(7, 7, 7, 7);
        step();
        load = 0;
        for (int k = 0; k < 2 * FR; k++) begin
            step();
            if (anode_out == 4'hE) begin
                if (k < FR) f1 = seg_out;
                else f2 = seg_out;
            end
            n_checks++;
            if ({seg_out, anode_out, digit_idx, frame_tick} !== {exp_seg, exp_an, exp_idx, exp_tick}) begin
                n_fail++;
                $display("FAIL load_bnd E=%0d: got %h/%h/%0d/%0d want %h/%h/%0d/%0d", E,
                         seg_out, anode_out, digit_idx, frame_tick, exp_seg, exp_an, exp_idx, exp_tick);
            end
        end
        n_checks++;
        if ({f1, f2} !== {8'h92, 8'hF8}) begin
            n_fail++;
            $display("FAIL load_order: digit0 got %h then %h want 92 then F8", f1, f2);
        end
    endtask

    task automatic test_enable_hold();
        for (int k = 0; k < 64 && (E % FR) != 2 * RD + 2; k++) step();
        enable = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++;
            if ({seg_out, anode_out, digit_idx, frame_tick} !== {8'hFF, 4'hF, 2'd2, 1'b0}) begin
                n_fail++;
                $display("FAIL hold: got %h/%h/%0d/%0d want FF/F/2/0",
                         seg_out, anode_out, digit_idx, frame_tick);
            end
        end
        enable = 1;
        for (int k = 0; k < 24; k++) begin
            step();
            n_checks++;
            if ({seg_out, anode_out, digit_idx, frame_tick} !== {exp_seg, exp_an, exp_idx, exp_tick}) begin
                n_fail++;
                $display("FAIL resume E=%0d: got %h/%h/%0d/%0d want %h/%h/%0d/%0d", E,
                         seg_out, anode_out, digit_idx, frame_tick, exp_seg, exp_an, exp_idx, exp_tick);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 64 && !((E % RD) == 2 && (E / RD) % N == 1); k++) step();
        rst = 1;
        step();
        rst = 0;
        n_checks++;
        if ({seg_out, anode_out, digit_idx, frame_tick} !== {8'hFF, 4'hF, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: got %h/%h/%0d/%0d want FF/F/0/0",
                     seg_out, anode_out, digit_idx, frame_tick);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            enable   = ($urandom_range(0, 9) != 0);
            load     = ($urandom_range(0, 24) == 0);
            rst      = ($urandom_range(0, 499) == 0);
            codes_in = 20'($urandom);
            dp_in    = 4'($urandom);
            blank_in = 4'($urandom) & 4'($urandom);
            blink_in = 4'($urandom);
            step();
            n_checks++;
            if ({seg_out, anode_out, digit_idx, frame_tick} !== {exp_seg, exp_an, exp_idx, exp_tick}) begin
                n_fail++;
                $display("FAIL random k=%0d: got %h/%h/%0d/%0d want %h/%h/%0d/%0d", k,
                         seg_out, anode_out, digit_idx, frame_tick, exp_seg, exp_an, exp_idx, exp_tick);
            end
        end
        rst = 0; load = 0; enable = 1;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_dp_codes();
        test_blink();
        test_load_timing();
        test_enable_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
